// File: rtl/a23_cache_pkg.sv
// Shared types and constants for the A23 cache flush sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package a23_cache_pkg;

    // Sequencer states: IDLE waits for a flush request, FLUSH walks the tag RAM.
    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

    // Address bits that select one 2MB cacheable region out of 32.
    localparam int REGION_LSB = 21;
    localparam int REGION_MSB = 25;

    localparam int DEFAULT_CACHE_LINES = 256;
    localparam int DEFAULT_WAYS        = 4;

endpackage

// File: rtl/a23_cache_flush_seq.sv
// Invalidates every tag-RAM line (all ways at once) after reset and on each CP15 flush strobe.
// Latency: strobe at N -> writes N+1..N+CACHE_LINES -> o_flush_done at N+CACHE_LINES+1.
// Backpressure: i_tag_busy holds the current index (write enable dropped) for that cycle.
//
// Ports:
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_cache_enable           CP15 cache-on level (only affects o_addr_cacheable)
//   i_cache_flush            one-cycle flush strobe
//   i_cacheable_area         one bit per 2MB region
//   i_address                current core access address
//   i_tag_busy               tag RAM owned by a line fill this cycle
//   o_tag_wen/o_tag_widx     per-way invalidate write enable and line index
//   o_tag_wdata_valid        valid bit written (always 0)
//   o_flush_busy             core stall request while walking
//   o_flush_done             one-cycle pulse after the last line write
//   o_addr_cacheable         cacheability of i_address, forced 0 while flushing
module a23_cache_flush_seq
    import a23_cache_pkg::*;
#(
    parameter int  CACHE_LINES = DEFAULT_CACHE_LINES,
    parameter int  WAYS        = DEFAULT_WAYS,
    localparam int IDX_W       = $clog2(CACHE_LINES)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cache_enable,
    input  logic             i_cache_flush,
    input  logic [31:0]      i_cacheable_area,
    input  logic [31:0]      i_address,
    input  logic             i_tag_busy,
    output logic [WAYS-1:0]  o_tag_wen,
    output logic [IDX_W-1:0] o_tag_widx,
    output logic             o_tag_wdata_valid,
    output logic             o_flush_busy,
    output logic             o_flush_done,
    output logic             o_addr_cacheable
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CACHE_LINES - 1);

    flush_state_t     state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             init_pending, init_pending_nxt;
    logic             req_pending, req_pending_nxt;
    logic             flush_done_q, flush_done_nxt;

    logic [REGION_MSB-REGION_LSB:0] region;
    logic                           in_flush;
    logic                           unused_addr_bits;

    assign region           = i_address[REGION_MSB:REGION_LSB];
    assign unused_addr_bits = ^{i_address[31:REGION_MSB+1], i_address[REGION_LSB-1:0]};

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            init_pending <= 1'b1;
            req_pending  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            init_pending <= init_pending_nxt;
            req_pending  <= req_pending_nxt;
            flush_done_q <= flush_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt        = state;
        idx_nxt          = idx;
        init_pending_nxt = init_pending;
        req_pending_nxt  = req_pending;
        flush_done_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (init_pending || req_pending || i_cache_flush) begin
                    state_nxt        = FLUSH;
                    idx_nxt          = '0;
                    init_pending_nxt = 1'b0;
                    req_pending_nxt  = 1'b0;
                end
            end
            FLUSH: begin
                if (!i_tag_busy && idx == LAST_IDX) begin
                    idx_nxt = '0;
                    // A strobe landing on the final write folds straight into the
                    // restart rather than being queued behind it.
                    if (req_pending || i_cache_flush) begin
                        req_pending_nxt = 1'b0;
                    end else begin
                        state_nxt      = IDLE;
                        flush_done_nxt = 1'b1;
                    end
                end else begin
                    if (!i_tag_busy) begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                    // Any number of strobes mid-walk coalesce into one extra pass.
                    if (i_cache_flush) begin
                        req_pending_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs; everything is held at 0 while reset is asserted, including the
    // cycle in which reset first drops mid-walk.
    always_comb begin
        in_flush          = i_rst_n && (state == FLUSH);
        o_tag_wen         = {WAYS{in_flush && !i_tag_busy}};
        o_tag_widx        = in_flush ? idx : '0;
        o_tag_wdata_valid = 1'b0;
        o_flush_busy      = in_flush;
        o_flush_done      = i_rst_n && flush_done_q;
        o_addr_cacheable  = i_rst_n && i_cache_enable && i_cacheable_area[region]
                            && (state != FLUSH);
    end

endmodule

// File: tb/tb_a23_cache_flush_seq.sv
// Bench for a23_cache_flush_seq with CACHE_LINES=8, WAYS=4.
// Latency: n/a.
// Backpressure: drives i_tag_busy directly.
module tb_a23_cache_flush_seq;

    localparam int LINES = 8;
    localparam int NW    = 4;

    logic            i_clk = 1'b0;
    logic            i_rst_n;
    logic            i_cache_enable;
    logic            i_cache_flush;
    logic [31:0]     i_cacheable_area;
    logic [31:0]     i_address;
    logic            i_tag_busy;
    logic [NW-1:0]   o_tag_wen;
    logic [2:0]      o_tag_widx;
    logic            o_tag_wdata_valid;
    logic            o_flush_busy;
    logic            o_flush_done;
    logic            o_addr_cacheable;

    a23_cache_flush_seq #(.CACHE_LINES(LINES), .WAYS(NW)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_cache_enable   (i_cache_enable),
        .i_cache_flush    (i_cache_flush),
        .i_cacheable_area (i_cacheable_area),
        .i_address        (i_address),
        .i_tag_busy       (i_tag_busy),
        .o_tag_wen        (o_tag_wen),
        .o_tag_widx       (o_tag_widx),
        .o_tag_wdata_valid(o_tag_wdata_valid),
        .o_flush_busy     (o_flush_busy),
        .o_flush_done     (o_flush_done),
        .o_addr_cacheable (o_addr_cacheable)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: queue of line indices still owed to the tag RAM, plus flags.
    int   mq[$];
    bit   m_extra;
    bit   m_init;
    bit   m_done;
    int   wlog[$];   // indices of accepted writes, in order
    int   n_done = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_pass();
        for (int k = 0; k < LINES; k++) mq.push_back(k);
    endtask

    // One clock: compare at negedge against the model, advance the model as the
    // posedge will, then return just after the posedge so the caller can drive.
    task automatic step();
        bit   e_busy, e_done, e_ca, strobe, accepted;
        logic [NW-1:0] e_wen;
        int   e_idx;
        @(negedge i_clk);
        strobe = i_cache_flush;
        if (!i_rst_n) begin
            e_busy = 0; e_wen = '0; e_idx = 0; e_done = 0; e_ca = 0;
        end else begin
            e_busy = (mq.size() != 0);
            e_wen  = (e_busy && !i_tag_busy) ? {NW{1'b1}} : '0;
            e_idx  = e_busy ? mq[0] : 0;
            e_done = m_done;
            e_ca   = i_cache_enable && i_cacheable_area[i_address[25:21]] && !e_busy;
        end
        chk("tag_wen",        32'(o_tag_wen),        32'(e_wen));
        chk("tag_widx",       32'(o_tag_widx),       32'(e_idx));
        chk("tag_wdata_vld",  32'(o_tag_wdata_valid), 32'(0));
        chk("flush_busy",     32'(o_flush_busy),     32'(e_busy));
        chk("flush_done",     32'(o_flush_done),     32'(e_done));
        chk("addr_cacheable", 32'(o_addr_cacheable), 32'(e_ca));
        if (i_rst_n && o_tag_wen != '0) wlog.push_back(int'(o_tag_widx));
        if (o_flush_done) n_done++;

        if (!i_rst_n) begin
            mq.delete(); m_extra = 0; m_init = 1; m_done = 0;
        end else begin
            m_done = 0;
            if (mq.size() == 0) begin
                if (m_init || m_extra || strobe) begin
                    push_pass(); m_init = 0; m_extra = 0;
                end
            end else begin
                accepted = !i_tag_busy;
                if (accepted) void'(mq.pop_front());
                if (accepted && mq.size() == 0) begin
                    if (m_extra || strobe) begin push_pass(); m_extra = 0; end
                    else m_done = 1;
                end else if (strobe) begin
                    m_extra = 1;
                end
            end
        end
        @(posedge i_clk);
        cyc++;
        #1;
    endtask

    task automatic wait_done(input string nm, output int dc);
        int n = 0;
        while (!o_flush_done && n < 100) begin step(); n++; end
        if (!o_flush_done) begin
            chk({nm, "_timeout"}, 32'(0), 32'(1));
            dc = -1;
        end else dc = cyc;
    endtask

    task automatic wait_idx(input string nm, input int want);
        int n = 0;
        while (!(o_flush_busy && int'(o_tag_widx) == want) && n < 100) begin step(); n++; end
        if (n >= 100) chk({nm, "_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic chk_pass_log(input string nm, input int base, input int passes);
        chk({nm, "_nwrites"}, 32'(wlog.size() - base), 32'(passes * LINES));
        for (int k = 0; k < passes * LINES && base + k < wlog.size(); k++)
            chk({nm, "_widx_seq"}, 32'(wlog[base + k]), 32'(k % LINES));
    endtask

    initial begin
        int rel, n0, wb, db, dc;
        i_rst_n = 0; i_cache_enable = 0; i_cache_flush = 0;
        i_cacheable_area = '0; i_address = '0; i_tag_busy = 0;
        m_extra = 0; m_init = 1; m_done = 0;

        // Reset and automatic initial flush
        repeat (3) step();
        chk("reset_busy", 32'(o_flush_busy), 32'(0));
        i_rst_n = 1; rel = cyc; wb = wlog.size(); db = n_done;
        #1 chk("release_busy", 32'(o_flush_busy), 32'(0));
        step();
        chk("init_busy_lat", 32'(o_flush_busy), 32'(1));
        chk("init_busy_cyc", 32'(cyc - rel), 32'(1));
        wait_done("init", dc);
        chk("init_done_cyc", 32'(dc - rel), 32'(9));
        chk_pass_log("init", wb, 1);
        step();
        chk("init_idle_busy", 32'(o_flush_busy), 32'(0));
        chk("init_ndone", 32'(n_done - db), 32'(1));

        // Single strobe from IDLE
        repeat (2) step();
        n0 = cyc; wb = wlog.size(); db = n_done;
        i_cache_flush = 1; step(); i_cache_flush = 0;
        wait_done("strobe", dc);
        chk("strobe_done_cyc", 32'(dc - n0), 32'(9));
        chk_pass_log("strobe", wb, 1);

        // Strobe with tag RAM busy for 2 cycles at idx 3
        repeat (2) step();
        n0 = cyc; wb = wlog.size();
        i_cache_flush = 1; step(); i_cache_flush = 0;
        wait_idx("stall", 3);
        i_tag_busy = 1;
        #1 chk("stall_wen", 32'(o_tag_wen), 32'(0));
        step();
        chk("stall_idx_hold", 32'(o_tag_widx), 32'(3));
        step();
        i_tag_busy = 0;
        wait_done("stall", dc);
        chk("stall_done_cyc", 32'(dc - n0), 32'(11));
        chk_pass_log("stall", wb, 1);

        // Two strobes mid-walk coalesce into one extra pass
        repeat (2) step();
        n0 = cyc; wb = wlog.size(); db = n_done;
        i_cache_flush = 1; step(); i_cache_flush = 0;
        wait_idx("coal2", 2);
        i_cache_flush = 1; step(); i_cache_flush = 0;
        wait_idx("coal5", 5);
        i_cache_flush = 1; step(); i_cache_flush = 0;
        wait_done("coal", dc);
        chk("coal_done_cyc", 32'(dc - n0), 32'(17));
        repeat (3) step();
        chk_pass_log("coal", wb, 2);
        chk("coal_ndone", 32'(n_done - db), 32'(1));

        // Reset in the middle of a walk
        i_cache_flush = 1; step(); i_cache_flush = 0;
        wait_idx("rst4", 4);
        db = n_done;
        i_rst_n = 0;
        #1 chk("midrst_busy", 32'(o_flush_busy), 32'(0));
        repeat (2) step();
        chk("midrst_ndone", 32'(n_done - db), 32'(0));
        i_rst_n = 1; rel = cyc; wb = wlog.size(); db = n_done;
        wait_done("midrst", dc);
        chk("midrst_done_cyc", 32'(dc - rel), 32'(9));
        chk_pass_log("midrst", wb, 1);
        step();
        chk("midrst_ndone2", 32'(n_done - db), 32'(1));

        // Cacheability decision
        repeat (2) step();
        i_cache_enable = 1; i_cacheable_area = 32'h0000_0002; i_address = 32'h0020_0000;
        #1 chk("ca_region1", 32'(o_addr_cacheable), 32'(1));
        i_address = 32'h0040_0000;
        #1 chk("ca_region2", 32'(o_addr_cacheable), 32'(0));
        step();
        i_address = 32'h0020_0000; i_cache_flush = 1; step(); i_cache_flush = 0;
        #1 chk("ca_flushing", 32'(o_addr_cacheable), 32'(0));
        i_cache_enable = 0; step(); i_cache_enable = 1; step();
        #1 chk("ca_flushing2", 32'(o_addr_cacheable), 32'(0));
        wait_done("ca", dc);
        step();
        #1 chk("ca_after", 32'(o_addr_cacheable), 32'(1));
        i_cache_enable = 0;
        #1 chk("ca_disabled", 32'(o_addr_cacheable), 32'(0));
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/a23_cache_flush_seq.md
Name: a23_cache_flush_seq

Overview:
- Sequencer downstream of the CP15 coprocessor. Consumes the cache-enable level, the one-cycle flush strobe and the cacheable-area mask.
- Walks every cache line index and drives invalidating tag-RAM writes; stalls the core while it runs.
- After reset, runs one automatic initial flush so the tag RAM never holds power-up garbage.
- Also gives the cache a registered-state cacheability decision for the current core address.

Parameters:
- CACHE_LINES, 256, lines per way; power of 2, minimum 4.
- WAYS, 4, ways written in parallel on each invalidate.
- IDX_W, $clog2(CACHE_LINES), line index width; derived, not overridden.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  synchronous active-low reset
- i_cache_enable  in  1  CP15 cache-on level
- i_cache_flush  in  1  one-cycle flush strobe from CP15, already qualified by fetch stall
- i_cacheable_area  in  32  one bit per 2MB region
- i_address  in  32  current core access address
- i_tag_busy  in  1  tag RAM owned by a line fill this cycle; write not accepted
- o_tag_wen  out  WAYS  per-way tag write enable; all ones when writing
- o_tag_widx  out  IDX_W  line index being invalidated
- o_tag_wdata_valid  out  1  valid bit written; constant 0
- o_flush_busy  out  1  stall request to core; high in FLUSH
- o_flush_done  out  1  one-cycle pulse after the final line write
- o_addr_cacheable  out  1  i_cache_enable & i_cacheable_area[i_address[25:21]] & !o_flush_busy

Behaviour:
- Interface: one clock i_clk; reset i_rst_n is synchronous, active-low. No asynchronous logic.
- States: IDLE, FLUSH.
- Reset (i_rst_n low at a clock edge):
  - state=IDLE, idx=0, init_pending=1, req_pending=0, o_flush_done=0.
  - All outputs 0 while in reset.
- IDLE:
  - If init_pending or req_pending or i_cache_flush: go to FLUSH, idx=0, clear init_pending and req_pending.
  - The first edge with i_rst_n high moves to FLUSH, so writes begin on the 2nd cycle after reset release.
- FLUSH:
  - o_tag_wen = {WAYS{~i_tag_busy}}; o_tag_widx = idx.
  - idx advances only when i_tag_busy=0.
  - When idx==CACHE_LINES-1 and the write is accepted:
    - If req_pending or i_cache_flush is high: restart at idx=0, clear req_pending, stay in FLUSH, no done pulse.
    - Otherwise: go to IDLE, idx=0, o_flush_done=1 for exactly the next cycle.
- Flush strobe arriving during FLUSH (not on the last accepted write): sets req_pending. Multiple strobes coalesce to one extra full pass.
- Latency, no busy: strobe at cycle N → FLUSH at N+1 → writes on N+1..N+CACHE_LINES → o_flush_done at N+CACHE_LINES+1. Each busy cycle adds one cycle.
- i_cache_enable toggling has no effect on a flush in progress.
- o_addr_cacheable is 0 throughout FLUSH.
- Reset mid-FLUSH: abandons the walk, no done pulse, then the initial flush reruns from idx 0.
- idx wraps modulo CACHE_LINES; it never writes index ≥ CACHE_LINES.
- o_tag_wen, o_tag_widx and o_flush_busy are combinational from registered state plus i_tag_busy. o_flush_done is registered.

Decomposition:
- Shared package a23_cache_pkg:
  - state enum (IDLE, FLUSH)
  - REGION_LSB=21, REGION_MSB=25 for the cacheable-region select
  - default CACHE_LINES and WAYS
- No sub-module; the region lookup is a single mux kept inline.

Test Plan (bench uses CACHE_LINES=8, WAYS=4):
- Reset low 3 cycles, then release, i_tag_busy=0:
  - busy rises 2nd cycle after release.
  - o_tag_wen=4'hF with idx 0..7 over 8 cycles.
  - o_flush_done pulses once the next cycle; busy then 0.
- From IDLE, one-cycle i_cache_flush at cycle N:
  - writes idx 0..7 on N+1..N+8; o_flush_done at N+9.
- Same flush with i_tag_busy high at idx 3 for 2 cycles:
  - o_tag_wen=0 and idx held at 3 during those cycles; done at N+11.
- Two strobes during a flush (at idx 2 and idx 5):
  - exactly one extra pass (16 writes total, idx 0..7 twice); single done pulse at the end.
- Reset asserted at idx 4:
  - outputs 0 during reset, no done pulse; after release a full 0..7 pass plus one done pulse.
- IDLE, i_cache_enable=1, i_cacheable_area=32'h0000_0002:
  - i_address=32'h0020_0000 → o_addr_cacheable=1.
  - i_address=32'h0040_0000 → 0.
  - Same addresses during FLUSH → 0.
  - i_cache_enable=0 → 0.
